// File: rtl/mux_scan.sv
// Registered N-to-1 channel mux with manual select and auto-scan (DWELL cycles per channel).
// Latency: one cycle from the sampling edge to y/ch/valid/wrap; no combinational input-to-output path.
// Backpressure: none; a new sample is presented every enabled cycle and valid marks legitimate samples.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   x          : N*W packed channel data, channel k at x[k*W +: W]
//   c          : manual channel select
//   mode       : 0 = manual, 1 = auto-scan
//   en         : block enable; when low, y/ch hold and valid drops
//   y, ch      : registered sample and the channel it came from
//   valid      : y/ch carry a legitimate sample
//   wrap       : pulses on the final sample of channel N-1 while scanning
module mux_scan #(
    parameter int W     = 1,
    parameter int N     = 4,
    parameter int DWELL = 4,
    localparam int SW   = (N > 2) ? $clog2(N) : 1,
    localparam int DW   = (DWELL > 2) ? $clog2(DWELL) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  x,
    input  logic [SW-1:0]   c,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            wrap
);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic [SW-1:0]   p_q, p_d;
    logic [DW-1:0]   d_q, d_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    logic [W-1:0]    x_at_c, x_at_p;
    logic            c_in_range;
    logic [SW-1:0]   scan_p;
    logic [DW-1:0]   scan_d;
    logic            last_dwell, last_chan;

    // Scan position only carries over while already scanning; any other
    // entry into SCAN starts from channel 0 with a fresh dwell.
    assign scan_p     = (state_q == SCAN) ? p_q : '0;
    assign scan_d     = (state_q == SCAN) ? d_q : '0;
    assign last_dwell = (scan_d == DW'(DWELL - 1));
    assign last_chan  = (scan_p == SW'(N - 1));

    // Explicit match loop instead of a variable part-select, so an
    // out-of-range select (N not a power of two) never indexes past x.
    always_comb begin
        x_at_c     = '0;
        x_at_p     = '0;
        c_in_range = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (c == SW'(k)) begin
                x_at_c     = x[k*W +: W];
                c_in_range = 1'b1;
            end
            if (scan_p == SW'(k)) begin
                x_at_p = x[k*W +: W];
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        p_d     = '0;
        d_d     = '0;

        if (en) begin
            state_d = mode ? SCAN : MANUAL;
        end

        case (state_d)
            MANUAL: begin
                ch_d    = c;
                y_d     = c_in_range ? x_at_c : '0;
                valid_d = c_in_range;
            end
            SCAN: begin
                y_d     = x_at_p;
                ch_d    = scan_p;
                valid_d = 1'b1;
                wrap_d  = last_chan && last_dwell;
                if (last_dwell) begin
                    d_d = '0;
                    p_d = last_chan ? '0 : scan_p + SW'(1);
                end else begin
                    d_d = scan_d + DW'(1);
                    p_d = scan_p;
                end
            end
            default: begin
                // IDLE: y/ch hold, everything else already cleared.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            p_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            p_q     <= p_d;
            d_q     <= d_d;
        end
    end

    assign y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule
